dlt_stim_checker: RTL and testbench

- Self-checking stimulus sequencer for the CC_DLT latch-bank test case.
- Drives the shared d/g/sr inputs of a 24-latch bank and samples its 24-bit q.
- Latches 0..15 cover every G_INV/SR_INV/SR_VAL/INIT combination. Latches 16..23 cover every G_INV/SR_INV/SR_VAL combination with no INIT.
- Holds a cycle-accurate golden model of all 24 latches and reports mismatch count, first-failure location and pass/fail.

---
 rtl/dlt_stim_checker.sv | 143 ++++++++++++++
 tb/tb_dlt_stim_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dlt_stim_checker.sv
// Stimulus sequencer and golden-model checker for a 24-latch bank (CC_DLT).
// Walks a gray-coded {sr,g,d} pattern and accumulates per-bit mismatches against q.
module dlt_stim_checker #(
    parameter int PATTERN_LEN = 64,
    parameter int SETTLE      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] q,
    output logic        d,
    output logic        g,
    output logic        sr,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [4:0]  first_err_idx,
    output logic [5:0]  first_err_step
);

    // Latch j configuration: g_inv=j[0], sr_inv=j[1], sr_val=j[2], init=j[3] (j<16 only)
    localparam logic [23:0] G_INV  = 24'hAAAAAA;
    localparam logic [23:0] SR_INV = 24'hCCCCCC;
    localparam logic [23:0] SR_VAL = 24'hF0F0F0;
    localparam logic [23:0] INIT   = 24'h00FF00;
    localparam logic [23:0] KNOWN0 = 24'h00FFFF;
    localparam int          CW     = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [5:0]  LAST   = 6'(PATTERN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [5:0]    step;
    logic [CW-1:0] cnt;
    logic [23:0]   model, known, model_n, known_n;
    logic [23:0]   sr_act, g_open, mismatch;
    logic [4:0]    mm_cnt, mm_low;
    logic [8:0]    err_sum;
    logic [2:0]    gray;
    logic          start_run, do_check;

    function automatic logic [4:0] popcount24(input logic [23:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 24; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    // Golden model tracks the registered stimulus in every state.
    always_comb begin
        sr_act  = {24{sr}} ^ SR_INV;
        g_open  = {24{g}} ^ G_INV;
        model_n = (sr_act & SR_VAL) | (~sr_act & g_open & {24{d}}) | (~sr_act & ~g_open & model);
        known_n = known | sr_act | g_open;
    end

    always_comb begin
        mismatch = (q ^ model) & known;
        mm_cnt   = popcount24(mismatch);
        mm_low   = '0;
        for (int i = 23; i >= 0; i--) begin
            if (mismatch[i]) mm_low = 5'(i);
        end
        err_sum = {1'b0, err_count} + {4'b0, mm_cnt};
        gray    = step[2:0] ^ (step[2:0] >> 1);
    end

    always_comb begin
        state_n   = state;
        start_run = 1'b0;
        do_check  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_APPLY;
                    start_run = 1'b1;
                end
            end
            S_APPLY:  state_n = S_SETTLE;
            S_SETTLE: if (cnt == '0) state_n = S_CHECK;
            S_CHECK: begin
                do_check = 1'b1;
                state_n  = (step == LAST) ? S_DONE : S_APPLY;
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            step           <= '0;
            cnt            <= '0;
            d              <= 1'b0;
            g              <= 1'b0;
            sr             <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_step <= '0;
            model          <= INIT;
            known          <= KNOWN0;
        end else begin
            state <= state_n;
            model <= model_n;
            known <= known_n;
            if (start_run) begin
                step           <= '0;
                done           <= 1'b0;
                err_count      <= '0;
                first_err_idx  <= '0;
                first_err_step <= '0;
            end
            if (state == S_APPLY) begin
                {sr, g, d} <= gray;
                cnt        <= CW'(SETTLE - 1);
            end
            if (state == S_SETTLE && cnt != '0) cnt <= cnt - 1'b1;
            if (do_check) begin
                err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
                // err_count is still zero only if no earlier check in this run failed
                if (mismatch != '0 && err_count == '0) begin
                    first_err_idx  <= mm_low;
                    first_err_step <= step;
                end
                if (step != LAST) step <= step + 1'b1;
                else              done <= 1'b1;
            end
        end
    end

    assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_dlt_stim_checker.sv
// Scoreboarded bench: behavioural latch bank with injectable faults, reference
// predictions queued at start and compared by a monitor when done rises.
module tb_dlt_stim_checker;

    localparam int PATTERN_LEN = 64;
    localparam int SETTLE      = 2;
    localparam int PER         = 2 + SETTLE;

    logic        clk, rst, start;
    logic [23:0] q;
    logic        d, g, sr, busy, done, pass;
    logic [7:0]  err_count;
    logic [4:0]  first_err_idx;
    logic [5:0]  first_err_step;

    dlt_stim_checker #(.PATTERN_LEN(PATTERN_LEN), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .q(q),
        .d(d), .g(g), .sr(sr), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .first_err_step(first_err_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int err;
        int idx;
        int stp;
        int pss;
        int cyc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] bank;
    logic [23:0] f0 [PATTERN_LEN];
    logic [23:0] f1 [PATTERN_LEN];
    logic [23:0] fx [PATTERN_LEN];
    logic [5:0]  cur_step = '0;
    logic [23:0] rv, rk;
    int          busy_cnt = 0;
    logic        done_q = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Behavioural latch bank: transparent/set/reset behaviour of each cell.
    always @(d or g or sr or rst) begin
        if (rst) begin
            bank[15:0]  = 16'hFF00;
            bank[23:16] = 8'($urandom);
        end
        for (int j = 0; j < 24; j++) begin
            if (sr != ((j >> 1) & 1)) bank[j] = 1'((j >> 2) & 1);
            else if (g != (j & 1))    bank[j] = d;
        end
    end

    assign q = ((bank & ~f0[cur_step]) | f1[cur_step]) ^ fx[cur_step];

    task automatic ref_reset();
        rv = 24'h00FF00;
        rk = 24'h00FFFF;
    endtask

    // Step-by-step prediction of what a correct checker reports for this fault set.
    task automatic predict(output exp_t e);
        int st, gs, tot;
        logic [23:0] qq, mm;
        bit found;
        tot = 0; found = 0;
        e.idx = 0; e.stp = 0;
        for (int s = 0; s < PATTERN_LEN; s++) begin
            st = s % 8;
            gs = st ^ (st >> 1);
            for (int j = 0; j < 24; j++) begin
                if (((gs >> 2) & 1) != ((j >> 1) & 1)) begin
                    rv[j] = 1'((j >> 2) & 1); rk[j] = 1'b1;
                end else if (((gs >> 1) & 1) != (j & 1)) begin
                    rv[j] = 1'(gs & 1); rk[j] = 1'b1;
                end
            end
            qq  = ((rv & ~f0[s]) | f1[s]) ^ fx[s];
            mm  = (qq ^ rv) & rk;
            tot = tot + $countones(mm);
            if (tot > 255) tot = 255;
            if (mm != 0 && !found) begin
                found = 1;
                e.stp = s;
                for (int j = 23; j >= 0; j--) if (mm[j]) e.idx = j;
            end
        end
        e.err = tot;
        e.pss = (tot == 0);
        e.cyc = PATTERN_LEN * PER;
    endtask

    task automatic set_faults(input int mode);
        for (int s = 0; s < PATTERN_LEN; s++) begin
            f0[s] = '0; f1[s] = '0; fx[s] = '0;
            case (mode)
                1: f0[s] = 24'h000020;
                2: if (s < 2) f1[s] = 24'h010000;
                3: fx[s] = 24'hFFFFFF;
                4: begin
                    if ($urandom_range(0, 5) == 0) fx[s] = 24'h1 << $urandom_range(0, 23);
                    if ($urandom_range(0, 9) == 0) f0[s] = 24'h1 << $urandom_range(0, 23);
                    if ($urandom_range(0, 9) == 0) f1[s] = 24'h1 << $urandom_range(0, 23);
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_d", d, 0);
        chk("rst_g", g, 0);
        chk("rst_sr", sr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_idx", first_err_idx, 0);
        chk("rst_first_err_step", first_err_step, 0);
    endtask

    task automatic run(input int mode, input int abort_step, input bit restart);
        exp_t e;
        bit   ok;
        set_faults(mode);
        if (abort_step < 0) begin
            predict(e);
            sbq.push_back(e);
        end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; cur_step = '0;
        for (int c = 1; c <= PATTERN_LEN * PER; c++) begin
            @(posedge clk); #1;
            cur_step = 6'((c / PER > PATTERN_LEN - 1) ? PATTERN_LEN - 1 : c / PER);
            start    = restart && (c == 50);
            if (abort_step >= 0 && c == abort_step * PER + 1) begin
                rst = 1'b1;
                ref_reset();
                @(negedge clk);
                chk_reset_outputs();
                @(negedge clk);
                rst = 1'b0;
                cur_step = '0;
                set_faults(0);
                return;
            end
        end
        start = 1'b0;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = done;
        end
        chk("done_timeout", ok, 1);
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("err_count", err_count, e.err);
                    chk("first_err_idx", first_err_idx, e.idx);
                    chk("first_err_step", first_err_step, e.stp);
                    chk("pass", pass, e.pss);
                    chk("busy_cycles", busy_cnt, e.cyc);
                    chk("busy_low_at_done", busy, 0);
                end
                busy_cnt = 0;
            end
            done_q = done;
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0;
        set_faults(0);
        ref_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        run(2, -1, 0);   // q[16] stuck high while its gate is still closed
        run(0, -1, 0);   // ideal bank
        run(1, -1, 0);   // q[5] stuck low
        run(3, -1, 0);   // every bit inverted, saturating count
        run(0, -1, 1);   // stray start mid-run
        run(0, 10, 0);   // reset at step 10
        run(0, -1, 0);
        for (int k = 0; k < 3; k++) run(4, -1, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got 1 want 0");
        $fatal(1);
    end

endmodule
